// File: rtl/pipeline_pkg.sv
// Shared types for the IF-stage PC unit: FSM states,
// trap cause codes and the default fetch step.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    TRAP
  } pc_state_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_RANGE    = 2'd2,
    EXC_FALLOFF  = 2'd3
  } exc_cause_t;

  localparam int DEFAULT_STEP = 4;

endpackage

// File: rtl/pc_target_check.sv
// Validates a candidate PC (redirect target or PC+STEP)
// against memory range and fetch alignment.
module pc_target_check
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STEP       = DEFAULT_STEP,
  parameter int IMEM_BYTES = 128
) (
  input  logic [ADDR_W:0] cand,
  input  logic            is_redirect,
  output logic            ok,
  output exc_cause_t      cause
);

  localparam logic [ADDR_W+1:0] LIMIT =
    (ADDR_W+2)'(IMEM_BYTES);
  localparam logic [ADDR_W:0] MASK =
    (ADDR_W+1)'(STEP - 1);

  logic neg;
  logic over;
  logic mis;

  // Redirect targets are signed; sequential ones never are
  assign neg  = is_redirect & cand[ADDR_W];
  assign over = {1'b0, cand} >= LIMIT;
  assign mis  = |(cand & MASK);

  always_comb begin
    cause = EXC_NONE;
    if (neg || over) begin
      cause = is_redirect ? EXC_RANGE : EXC_FALLOFF;
    end else if (is_redirect && mis) begin
      cause = EXC_MISALIGN;
    end
    ok = (cause == EXC_NONE);
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: boot, stall, redirect, trap.
// Define PC_UNIT_TRACE_EN for a simulation trace.
module pc_unit
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STEP       = DEFAULT_STEP,
  parameter int IMEM_BYTES = 128,
  parameter int RESET_ADDR = 0,
  parameter int TRAP_ADDR  = 124,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] curr_addr,
  output logic              fetch_valid,
  output logic              pc_exc,
  output logic [1:0]        exc_cause,
  output logic [CNT_W-1:0]  adv_count
);

  localparam logic [ADDR_W-1:0] RST_A =
    ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] TRP_A =
    ADDR_W'(TRAP_ADDR);
  localparam logic [ADDR_W:0] STEP_V =
    (ADDR_W+1)'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pc_state_t  state;
  logic [ADDR_W:0] cand;
  logic       chk_ok;
  exc_cause_t chk_cause;

  // One checker serves both paths; extra bit keeps
  // the sign of redirects and the carry of PC+STEP
  assign cand = redirect_valid
    ? {redirect_addr[ADDR_W-1], redirect_addr}
    : {1'b0, curr_addr} + STEP_V;

  pc_target_check #(
    .ADDR_W     (ADDR_W),
    .STEP       (STEP),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_chk (
    .cand        (cand),
    .is_redirect (redirect_valid),
    .ok          (chk_ok),
    .cause       (chk_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      curr_addr   <= RST_A;
      fetch_valid <= 1'b0;
      pc_exc      <= 1'b0;
      exc_cause   <= EXC_NONE;
      adv_count   <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (redirect_valid || pc_write) begin
            if (chk_ok) begin
              curr_addr <= cand[ADDR_W-1:0];
              if (adv_count != CNT_MAX)
                adv_count <= adv_count + 1'b1;
            end else begin
              state       <= TRAP;
              curr_addr   <= TRP_A;
              fetch_valid <= 1'b0;
              pc_exc      <= 1'b1;
              exc_cause   <= chk_cause;
            end
          end
        end
        TRAP: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
          pc_exc      <= 1'b0;
          exc_cause   <= EXC_NONE;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_UNIT_TRACE_EN
  always @(posedge clk) begin
    $strobe("%0t state=%s pc=%h cause=%0d",
            $time, state.name(), curr_addr, exc_cause);
    if (rst_n && state == RUN && !chk_ok &&
        (redirect_valid || pc_write))
      $strobe("%0t *** TRAP cause=%0d",
              $time, chk_cause);
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: vector table through a scoreboard
// queue, plus reset and async-reset sequences.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pc_write;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic [7:0] curr_addr;
  logic       fetch_valid;
  logic       pc_exc;
  logic [1:0] exc_cause;
  logic [15:0] adv_count;
  logic [7:0] curr_addr2;
  logic       fetch_valid2;
  logic       pc_exc2;
  logic [1:0] exc_cause2;
  logic [3:0] adv_count2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       pw;
    logic       rv;
    logic [7:0] ra;
    logic [7:0] a;
    logic       fv;
    logic       ex;
    logic [1:0] c;
    int         cnt;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .curr_addr      (curr_addr),
    .fetch_valid    (fetch_valid),
    .pc_exc         (pc_exc),
    .exc_cause      (exc_cause),
    .adv_count      (adv_count)
  );

  pc_unit #(.CNT_W(4)) dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .curr_addr      (curr_addr2),
    .fetch_valid    (fetch_valid2),
    .pc_exc         (pc_exc2),
    .exc_cause      (exc_cause2),
    .adv_count      (adv_count2)
  );

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic add(vec_t q[$], output vec_t o[$],
                     input logic pw, input logic rv,
                     input int ra, input int a,
                     input logic fv, input logic ex,
                     input int c, input int cnt);
    vec_t v;
    v.pw = pw; v.rv = rv; v.ra = 8'(ra);
    v.a = 8'(a); v.fv = fv; v.ex = ex;
    v.c = 2'(c); v.cnt = cnt;
    o = q;
    o.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    pc_write       = v.pw;
    redirect_valid = v.rv;
    redirect_addr  = v.ra;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("addr[%0d]", idx), curr_addr, e.a);
      chk($sformatf("fv[%0d]", idx), fetch_valid, e.fv);
      chk($sformatf("exc[%0d]", idx), pc_exc, e.ex);
      chk($sformatf("cause[%0d]", idx), exc_cause, e.c);
      chk($sformatf("cnt[%0d]", idx), adv_count, e.cnt);
      chk($sformatf("cnt4[%0d]", idx), adv_count2,
          e.cnt > 15 ? 15 : e.cnt);
      chk($sformatf("addr4[%0d]", idx), curr_addr2, e.a);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"}, curr_addr, 0);
    chk({tag, "_fv"}, fetch_valid, 0);
    chk({tag, "_exc"}, pc_exc, 0);
    chk({tag, "_cause"}, exc_cause, 0);
    chk({tag, "_cnt"}, adv_count, 0);
    chk({tag, "_cnt4"}, adv_count2, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // pw rv ra  | addr fv ex cause cnt
    add(tbl1, tbl1, 1, 0, 0,    0,   1, 0, 0, 0);
    add(tbl1, tbl1, 1, 0, 0,    4,   1, 0, 0, 1);
    add(tbl1, tbl1, 1, 0, 0,    8,   1, 0, 0, 2);
    add(tbl1, tbl1, 1, 0, 0,    12,  1, 0, 0, 3);
    add(tbl1, tbl1, 1, 1, 8,    8,   1, 0, 0, 4);
    add(tbl1, tbl1, 0, 0, 0,    8,   1, 0, 0, 4);
    add(tbl1, tbl1, 0, 0, 0,    8,   1, 0, 0, 4);
    add(tbl1, tbl1, 0, 0, 0,    8,   1, 0, 0, 4);
    add(tbl1, tbl1, 0, 1, 'h40, 'h40, 1, 0, 0, 5);
    add(tbl1, tbl1, 1, 1, 'h42, 124, 0, 1, 1, 5);
    add(tbl1, tbl1, 1, 1, 0,    124, 1, 0, 0, 5);
    add(tbl1, tbl1, 1, 0, 0,    124, 0, 1, 3, 5);
    add(tbl1, tbl1, 0, 0, 0,    124, 1, 0, 0, 5);
    add(tbl1, tbl1, 0, 1, 'h80, 124, 0, 1, 2, 5);
    add(tbl1, tbl1, 0, 0, 0,    124, 1, 0, 0, 5);
    add(tbl1, tbl1, 1, 1, 'hF0, 124, 0, 1, 2, 5);
    add(tbl1, tbl1, 0, 0, 0,    124, 1, 0, 0, 5);
    add(tbl1, tbl1, 0, 1, 'h7D, 124, 0, 1, 1, 5);
    add(tbl1, tbl1, 0, 0, 0,    124, 1, 0, 0, 5);
    add(tbl1, tbl1, 0, 1, 120,  120, 1, 0, 0, 6);
    add(tbl1, tbl1, 1, 0, 0,    124, 1, 0, 0, 7);
    add(tbl1, tbl1, 1, 0, 0,    124, 0, 1, 3, 7);

    add(tbl2, tbl2, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      add(tbl2, tbl2, 1, 0, 0, 4 * k, 1, 0, 0, k);

    rst_n = 1'b0;
    pc_write = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    #12;
    chk_idle("rst");
    rst_n = 1'b1;
    #1;
    chk_idle("boot");

    for (int i = 0; i < tbl1.size(); i++)
      run_vec(tbl1[i], i);

    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    #10;
    rst_n = 1'b1;
    #1;
    chk_idle("reboot");
    pc_write = 1'b1;
    redirect_valid = 1'b0;

    for (int i = 0; i < tbl2.size(); i++)
      run_vec(tbl2[i], 100 + i);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
